// File: rtl/adder_stream_pkg.sv
// Shared definitions for the adder stream driver.
//   state_t        : driver FSM states (IDLE / SEND / WAIT_Z)
//   DEFAULT_WIDTH  : operand/result width of the float adder (IEEE-754 single)
package adder_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO holding operand pairs for the adder stream driver.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en      : push request; ignored while full
//   wr_data    : pushed entry
//   rd_en      : pop request; ignored while empty
//   rd_data    : current head entry (valid while !empty)
//   full,empty : occupancy flags, derived from registered pointers only
module pair_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/adder_stream_driver.sv
// Initiator for the float adder's stb/ack operand/result handshake.
// Operand pairs arrive on a valid/ready stream, are buffered in pair_fifo,
// are presented one at a time to the adder, and results leave on valid/ready.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_a, in_b, in_valid, in_ready: operand pair stream (in_ready = FIFO not full)
//   adder_a/_stb/_ack             : operand A handshake to the adder
//   adder_b/_stb/_ack             : operand B handshake to the adder
//   adder_z/_stb/_ack             : result handshake from the adder
//   res_z, res_valid, res_ready   : result stream
//   busy                          : FIFO non-empty, FSM active or result pending
//   issued_cnt, done_cnt          : wrapping counts of pairs delivered / results taken
module adder_stream_driver
    import adder_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] adder_a,
    output logic             adder_a_stb,
    input  logic             adder_a_ack,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_b_stb,
    input  logic             adder_b_ack,
    input  logic [WIDTH-1:0] adder_z,
    input  logic             adder_z_stb,
    output logic             adder_z_ack,
    output logic [WIDTH-1:0] res_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt
);

    state_t             state;
    logic               a_done;
    logic               b_done;
    logic [2*WIDTH-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               a_xfer;
    logic               b_xfer;
    logic               a_fin;
    logic               b_fin;
    logic               z_xfer;

    pair_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data ({in_a, in_b}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign pop      = (state == IDLE) && !fifo_empty;

    assign a_xfer = adder_a_stb && adder_a_ack;
    assign b_xfer = adder_b_stb && adder_b_ack;
    // An operand counts as delivered if it finished earlier or finishes this cycle.
    assign a_fin  = a_done || a_xfer;
    assign b_fin  = b_done || b_xfer;

    // Combinational so a result is taken in the same cycle it is offered,
    // but only when the result register is free.
    assign adder_z_ack = (state == WAIT_Z) && adder_z_stb && !res_valid;
    assign z_xfer      = adder_z_stb && adder_z_ack;

    assign busy = !fifo_empty || (state != IDLE) || res_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            adder_a     <= '0;
            adder_b     <= '0;
            adder_a_stb <= 1'b0;
            adder_b_stb <= 1'b0;
            res_z       <= '0;
            res_valid   <= 1'b0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
        end else begin
            // Drain first; a capture below overrides it in the same cycle.
            if (res_valid && res_ready) res_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        adder_a     <= head[2*WIDTH-1:WIDTH];
                        adder_b     <= head[WIDTH-1:0];
                        adder_a_stb <= 1'b1;
                        adder_b_stb <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (a_xfer) begin
                        adder_a_stb <= 1'b0;
                        a_done      <= 1'b1;
                    end
                    if (b_xfer) begin
                        adder_b_stb <= 1'b0;
                        b_done      <= 1'b1;
                    end
                    if (a_fin && b_fin) begin
                        issued_cnt <= issued_cnt + 1'b1;
                        a_done     <= 1'b0;
                        b_done     <= 1'b0;
                        state      <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (z_xfer) begin
                        res_z     <= adder_z;
                        res_valid <= 1'b1;
                        done_cnt  <= done_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_stream_driver.sv
// Self-checking bench for adder_stream_driver (DEPTH=4, CNT_W=4).
// A behavioural adder answers the stb/ack handshakes with programmable
// delays; expected results are a queue of float sums of accepted pairs.
module tb_adder_stream_driver;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_a, in_b;
    logic          in_valid, in_ready;
    logic [W-1:0]  adder_a, adder_b, adder_z;
    logic          adder_a_stb, adder_a_ack, adder_b_stb, adder_b_ack;
    logic          adder_z_stb, adder_z_ack;
    logic [W-1:0]  res_z;
    logic          res_valid, res_ready, busy;
    logic [CW-1:0] issued_cnt, done_cnt;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    adder_stream_driver #(
        .WIDTH (W),
        .DEPTH (4),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .adder_a     (adder_a),
        .adder_a_stb (adder_a_stb),
        .adder_a_ack (adder_a_ack),
        .adder_b     (adder_b),
        .adder_b_stb (adder_b_stb),
        .adder_b_ack (adder_b_ack),
        .adder_z     (adder_z),
        .adder_z_stb (adder_z_stb),
        .adder_z_ack (adder_z_ack),
        .res_z       (res_z),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .issued_cnt  (issued_cnt),
        .done_cnt    (done_cnt)
    );

    // ---------------- reference arithmetic ----------------
    function automatic real s2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2s(s2r(a) + s2r(b));
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural adder ----------------
    int unsigned a_delay = 0, b_delay = 0, z_lat = 0;
    bit          hold = 1'b0;
    logic [31:0] cap_a, cap_b;
    bit          have_a, have_b, xa, xb, xz;
    int unsigned ca, cb, cz;

    initial begin
        adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = '0;
        have_a = 0; have_b = 0; xa = 0; xb = 0; xz = 0; ca = 0; cb = 0; cz = 0;
        cap_a = '0; cap_b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
                have_a = 0; have_b = 0; xa = 0; xb = 0; xz = 0; ca = 0; cb = 0; cz = 0;
                continue;
            end
            if (xa) have_a = 1;
            if (xb) have_b = 1;
            if (xz) begin
                have_a = 0; have_b = 0; adder_z_stb = 1'b0; ca = 0; cb = 0; cz = 0;
            end
            adder_a_ack = 1'b0;
            adder_b_ack = 1'b0;
            if (adder_a_stb && !have_a && !hold) begin
                if (ca >= a_delay) begin adder_a_ack = 1'b1; cap_a = adder_a; end
                else ca++;
            end
            if (adder_b_stb && !have_b && !hold) begin
                if (cb >= b_delay) begin adder_b_ack = 1'b1; cap_b = adder_b; end
                else cb++;
            end
            if (have_a && have_b && !adder_z_stb && !xz) begin
                if (cz >= z_lat) begin adder_z = fadd(cap_a, cap_b); adder_z_stb = 1'b1; end
                else cz++;
            end
            #1;
            xa = adder_a_stb && adder_a_ack;
            xb = adder_b_stb && adder_b_ack;
            xz = adder_z_stb && adder_z_ack;
            if (!adder_z_stb) check("z_ack_without_stb", {31'd0, adder_z_ack}, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] exp_q[$];
    int unsigned total = 0;

    // Called at a negedge; returns whether the pair was accepted.
    task automatic push(input logic [31:0] a, input logic [31:0] b, output bit ok);
        in_a = a; in_b = b; in_valid = 1'b1;
        ok = in_ready;
        if (ok) begin exp_q.push_back(fadd(a, b)); total++; end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect();
        int unsigned n = 0;
        while (!res_valid && n < 300) begin @(negedge clk); n++; end
        if (!res_valid) begin
            check("res_timeout", {31'd0, res_valid}, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("res_unexpected", {31'd0, res_valid}, 32'd0);
        end else begin
            check("res_z", res_z, exp_q.pop_front());
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        check("idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_send();
        int unsigned n = 0;
        while (!adder_a_stb && n < 100) begin @(negedge clk); n++; end
        check("send_reached", {31'd0, adder_a_stb}, 32'd1);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_issued"}, 32'(issued_cnt), 32'(total % 16));
        check({tag, "_done"},   32'(done_cnt),   32'(total % 16));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int unsigned low_cycles;
        bit          a_stable;
        logic [31:0] ta, tb;
        int unsigned sent, burst, n;

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = '0; in_b = '0;

        // Reset state
        #1000;
        check("rst_in_ready",  {31'd0, in_ready},    32'd1);
        check("rst_res_valid", {31'd0, res_valid},   32'd0);
        check("rst_a_stb",     {31'd0, adder_a_stb}, 32'd0);
        check("rst_b_stb",     {31'd0, adder_b_stb}, 32'd0);
        check("rst_busy",      {31'd0, busy},        32'd0);
        check("rst_adder_a",   adder_a,              32'd0);
        check("rst_res_z",     res_z,                32'd0);
        check_counts("rst");
        @(negedge clk);
        rst = 1'b0;

        // 1. Single pair: 1.0 + 2.0
        a_delay = 0; b_delay = 0; z_lat = 3;
        push(32'h3F800000, 32'h40000000, ok);
        check("t1_accept", {31'd0, ok}, 32'd1);
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        check("t1_res_const", res_z, 32'h40400000);
        collect();
        wait_idle();
        check_counts("t1");

        // 2. Fill FIFO while the adder stalls the first pair
        hold = 1'b1;
        push(rand_float(), rand_float(), ok);
        wait_send();
        for (int i = 0; i < 4; i++) begin
            push(rand_float(), rand_float(), ok);
            check("t2_accept", {31'd0, ok}, 32'd1);
        end
        check("t2_full", {31'd0, in_ready}, 32'd0);
        push(rand_float(), rand_float(), ok);
        check("t2_overflow_ignored", {31'd0, ok}, 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) collect();
        wait_idle();
        check_counts("t2");

        // 3. A acked five cycles before B
        a_delay = 0; b_delay = 5; z_lat = 1;
        ta = rand_float(); tb = rand_float();
        push(ta, tb, ok);
        wait_send();
        low_cycles = 0; a_stable = 1'b1; n = 0;
        while (adder_b_stb && n < 50) begin
            if (!adder_a_stb) low_cycles++;
            if (adder_a !== ta) a_stable = 1'b0;
            if (adder_b !== tb) a_stable = 1'b0;
            @(negedge clk); n++;
        end
        check("t3_a_low_while_b", 32'(low_cycles), 32'd5);
        check("t3_data_stable", {31'd0, a_stable}, 32'd1);
        collect();
        wait_idle();
        check_counts("t3");

        // 4. Backpressure: two queued, downstream stalled
        a_delay = 0; b_delay = 0; z_lat = 2;
        push(rand_float(), rand_float(), ok);
        push(rand_float(), rand_float(), ok);
        repeat (40) @(negedge clk);
        check("t4_res_valid", {31'd0, res_valid},   32'd1);
        check("t4_res_held",  res_z,                exp_q[0]);
        check("t4_z_stb",     {31'd0, adder_z_stb}, 32'd1);
        check("t4_z_ack",     {31'd0, adder_z_ack}, 32'd0);
        collect();
        collect();
        wait_idle();
        check_counts("t4");

        // 5. Reset during SEND
        hold = 1'b1;
        push(rand_float(), rand_float(), ok);
        push(rand_float(), rand_float(), ok);
        wait_send();
        #2 rst = 1'b1;
        #1;
        check("t5_a_stb",     {31'd0, adder_a_stb}, 32'd0);
        check("t5_b_stb",     {31'd0, adder_b_stb}, 32'd0);
        check("t5_busy",      {31'd0, busy},        32'd0);
        check("t5_in_ready",  {31'd0, in_ready},    32'd1);
        check("t5_res_valid", {31'd0, res_valid},   32'd0);
        exp_q.delete();
        total = 0;
        check_counts("t5");
        @(negedge clk);
        rst = 1'b0;
        hold = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_result", {31'd0, res_valid}, 32'd0);

        // 6. 17 random pairs with random adder timing: counters wrap to 1
        sent = 0;
        while (sent < 17) begin
            burst = $urandom_range(1, 3);
            if (burst > 17 - sent) burst = 17 - sent;
            a_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3);
            z_lat   = $urandom_range(0, 4);
            for (int i = 0; i < int'(burst); i++) begin
                push(rand_float(), rand_float(), ok);
                check("t6_accept", {31'd0, ok}, 32'd1);
            end
            for (int i = 0; i < int'(burst); i++) collect();
            sent += burst;
        end
        wait_idle();
        check("t6_issued_wrap", 32'(issued_cnt), 32'd1);
        check("t6_done_wrap",   32'(done_cnt),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
